// File: rtl/fpu_pkg.sv
// Shared FPU package: operand width, multiplier tag type and common FP constants.
package fpu_pkg;

    localparam int unsigned FP_W      = 32;
    localparam int unsigned MAX_REQ   = 8;
    localparam int unsigned TAG_IDX_W = $clog2(MAX_REQ);

    // In-flight multiply tag: valid flag plus the index of the issuing requester.
    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } tag_t;

    // Constants used by the requester paths.
    localparam logic [FP_W-1:0] FP_ONE     = 32'h3F80_0000;
    localparam logic [FP_W-1:0] FP_TWO_P25 = 32'h4C00_0000;

    // Builds a tag from its fields.
    function automatic tag_t make_tag(input logic valid, input logic [TAG_IDX_W-1:0] idx);
        tag_t t;
        t.valid = valid;
        t.idx   = idx;
        return t;
    endfunction

endpackage

// File: rtl/fpu_mul_arbiter_if.sv
// Requester and multiplier bus of the shared mul32 arbiter.
// slave: arbiter side; master: requesters plus multiplier side.
interface fpu_mul_arbiter_if
    import fpu_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
);

    logic [NUM_REQ-1:0]      req_valid_i;
    logic [FP_W*NUM_REQ-1:0] req_a_i;
    logic [FP_W*NUM_REQ-1:0] req_b_i;
    logic [NUM_REQ-1:0]      req_ready_o;
    logic [NUM_REQ-1:0]      rsp_valid_o;
    logic [FP_W-1:0]         rsp_data_o;
    logic                    mul_valid_o;
    logic [FP_W-1:0]         mul_a_o;
    logic [FP_W-1:0]         mul_b_o;
    logic [FP_W-1:0]         mul_p_i;
    logic                    idle_o;

    modport slave (
        input  req_valid_i, req_a_i, req_b_i, mul_p_i,
        output req_ready_o, rsp_valid_o, rsp_data_o,
               mul_valid_o, mul_a_o, mul_b_o, idle_o
    );

    modport master (
        output req_valid_i, req_a_i, req_b_i, mul_p_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o,
               mul_valid_o, mul_a_o, mul_b_o, idle_o
    );

endinterface

// File: rtl/fpu_rr_pick.sv
// Combinational round-robin picker: first eligible index at or above ptr, wrapping.
module fpu_rr_pick #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   gidx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Scan NUM_REQ positions starting at ptr; the first eligible one wins.
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((32'(ptr) + k) % NUM_REQ);
            if (!found && eligible[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                gidx        = cand;
            end
        end
    end

endmodule

// File: rtl/fpu_mul_arbiter.sv
// Shares one fixed-latency mul32 among NUM_REQ requesters. A tag pipeline aligned
// with the multiplier latency routes each product back to its issuer.
// Optional build macro: FPU_MUL_ARB_PRIO_EN gives requester 0 fixed top priority.
module fpu_mul_arbiter
    import fpu_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    fpu_mul_arbiter_if.slave   bus
);

    localparam int unsigned IDX_W      = $clog2(NUM_REQ);
    localparam int unsigned TAG_STAGES = MUL_LAT + 1;

    logic [NUM_REQ-1:0] busy_q, busy_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               mul_valid_q, mul_valid_d;
    logic [FP_W-1:0]    mul_a_q, mul_a_d;
    logic [FP_W-1:0]    mul_b_q, mul_b_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [FP_W-1:0]    rsp_data_q, rsp_data_d;
    tag_t               tag_q [TAG_STAGES];
    tag_t               tag_d [TAG_STAGES];

    logic [NUM_REQ-1:0] eligible_c;
    logic [NUM_REQ-1:0] rr_grant_c;
    logic [IDX_W-1:0]   rr_gidx_c;
    logic [NUM_REQ-1:0] grant_c;
    logic [IDX_W-1:0]   gidx_c;
    logic               ptr_hold_c;
    logic               accept_c;
    tag_t               tag_out_c;
    logic [IDX_W-1:0]   rsp_idx_c;

    // A requester with a multiply in flight cannot be granted again.
    assign eligible_c = bus.req_valid_i & ~busy_q;

    fpu_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .eligible (eligible_c),
        .ptr      (ptr_q),
        .grant    (rr_grant_c),
        .gidx     (rr_gidx_c)
    );

    // Final grant: round-robin result, optionally overridden by requester 0.
    always_comb begin
        grant_c    = rr_grant_c;
        gidx_c     = rr_gidx_c;
        ptr_hold_c = 1'b0;
`ifdef FPU_MUL_ARB_PRIO_EN
        if (eligible_c[0]) begin
            grant_c    = NUM_REQ'(1);
            gidx_c     = '0;
            ptr_hold_c = 1'b1;
        end
`endif
    end

    assign accept_c  = |grant_c;
    assign tag_out_c = tag_q[MUL_LAT];
    assign rsp_idx_c = IDX_W'(tag_out_c.idx);

    // Next-state: issue on grant, retire on tag output, shift the tag pipeline.
    always_comb begin
        busy_d      = busy_q;
        ptr_d       = ptr_q;
        mul_valid_d = accept_c;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;

        if (tag_out_c.valid) begin
            rsp_valid_d       = NUM_REQ'(1) << rsp_idx_c;
            rsp_data_d        = bus.mul_p_i;
            busy_d[rsp_idx_c] = 1'b0;
        end

        if (accept_c) begin
            busy_d[gidx_c] = 1'b1;
            mul_a_d        = bus.req_a_i[FP_W*gidx_c +: FP_W];
            mul_b_d        = bus.req_b_i[FP_W*gidx_c +: FP_W];
            if (!ptr_hold_c) begin
                ptr_d = (gidx_c == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_c + IDX_W'(1);
            end
        end

        tag_d[0] = make_tag(accept_c, TAG_IDX_W'(gidx_c));
        for (int unsigned k = 1; k < TAG_STAGES; k++) begin
            tag_d[k] = tag_q[k-1];
        end
    end

    // State registers; reset discards all in-flight tags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q      <= '0;
            ptr_q       <= '0;
            mul_valid_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            for (int unsigned k = 0; k < TAG_STAGES; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            busy_q      <= busy_d;
            ptr_q       <= ptr_d;
            mul_valid_q <= mul_valid_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            for (int unsigned k = 0; k < TAG_STAGES; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

    // Output mapping.
    assign bus.req_ready_o = grant_c;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_data_o  = rsp_data_q;
    assign bus.mul_valid_o = mul_valid_q;
    assign bus.mul_a_o     = mul_a_q;
    assign bus.mul_b_o     = mul_b_q;
    assign bus.idle_o      = ~|busy_q;

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Testbench for fpu_mul_arbiter: model multiplier, response scoreboard,
// cycle table for round-robin, directed multi-cycle sequences.
module tb_fpu_mul_arbiter;
    import fpu_pkg::*;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned MUL_LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fpu_mul_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    fpu_mul_arbiter #(
        .NUM_REQ (NUM_REQ),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rsp_cnt = 0;

    typedef struct {
        int          idx;
        logic [31:0] data;
        int          cyc;
    } sb_t;
    sb_t sb [$];

    typedef struct {
        logic [3:0] valid;
        logic [3:0] ready;
        logic [3:0] rsp;
        logic       idle;
    } vec_t;
    vec_t tbl [12];

    logic [31:0] op_a [4];
    logic [31:0] op_b [4];
    logic        pend_v = 1'b0;
    logic [31:0] pend_a, pend_b;
    logic [31:0] mpipe [MUL_LAT];

    // Reference single-precision multiply for normal operands with exact products.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] da, db, dp;
        real r;
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {a[31] ^ b[31], 31'd0};
        da = {a[31], 11'(a[30:23]) + 11'd896, a[22:0], 29'd0};
        db = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
        r  = $bitstoreal(da) * $bitstoreal(db);
        dp = $realtobits(r);
        return {dp[63], 8'(dp[62:52] - 11'd896), dp[51:29]};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model multiplier: fixed MUL_LAT pipeline, unaware of reset.
    always @(posedge clk) begin
        mpipe[0] <= fp_mul(bus.mul_a_o, bus.mul_b_o);
        for (int k = 1; k < MUL_LAT; k++) mpipe[k] <= mpipe[k-1];
    end
    assign bus.mul_p_i = mpipe[MUL_LAT-1];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: issue check, response scoreboard, acceptance capture.
    always @(negedge clk) begin : mon
        int  idx;
        sb_t e;
        if (rst) begin
            sb.delete();
            pend_v = 1'b0;
        end else begin
            check("mul_valid", bus.mul_valid_o, pend_v);
            if (pend_v) begin
                check("mul_a", bus.mul_a_o, pend_a);
                check("mul_b", bus.mul_b_o, pend_b);
            end
            if (|bus.rsp_valid_o) begin
                rsp_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected got=%0b exp=none", bus.rsp_valid_o);
                end else begin
                    e = sb.pop_front();
                    check("rsp_valid", bus.rsp_valid_o, 64'(4'b0001 << e.idx));
                    check("rsp_data", bus.rsp_data_o, e.data);
                    check("rsp_latency", cyc, e.cyc);
                end
            end
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL rsp_missing got=none exp=req%0d", sb[0].idx);
                void'(sb.pop_front());
            end
            pend_v = 1'b0;
            if (|(bus.req_valid_i & bus.req_ready_o)) begin
                idx = 0;
                for (int i = 0; i < 4; i++) if (bus.req_ready_o[i]) idx = i;
                e.idx  = idx;
                e.data = fp_mul(op_a[idx], op_b[idx]);
                e.cyc  = cyc + int'(MUL_LAT) + 2;
                sb.push_back(e);
                pend_v = 1'b1;
                pend_a = op_a[idx];
                pend_b = op_b[idx];
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid_i = '0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic reset_checks(input string name);
        @(negedge clk);
        check({name, "_mul_valid"}, bus.mul_valid_o, 0);
        check({name, "_mul_a"}, bus.mul_a_o, 0);
        check({name, "_mul_b"}, bus.mul_b_o, 0);
        check({name, "_rsp_valid"}, bus.rsp_valid_o, 0);
        check({name, "_rsp_data"}, bus.rsp_data_o, 0);
        check({name, "_idle"}, bus.idle_o, 1);
        next_cycle();
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        bus.req_valid_i = '0;
        while (bus.idle_o !== 1'b1 && n < 30) begin
            next_cycle();
            n++;
        end
        check({name, "_idle"}, bus.idle_o, 1);
        next_cycle();
        next_cycle();
        check({name, "_sb_empty"}, sb.size(), 0);
    endtask

    task automatic drive_chk(input string name, input logic [3:0] v, input logic [3:0] exp_ready);
        bus.req_valid_i = v;
        @(negedge clk);
        check(name, bus.req_ready_o, exp_ready);
        next_cycle();
    endtask

    initial begin : wdog
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc0;
        op_a[0] = FP_ONE;       op_b[0] = 32'h40A0_0000;
        op_a[1] = 32'h3FC0_0000; op_b[1] = 32'h4000_0000;
        op_a[2] = 32'h4040_0000; op_b[2] = 32'h4040_0000;
        op_a[3] = FP_TWO_P25;   op_b[3] = 32'hBF00_0000;
        bus.req_a_i = {op_a[3], op_a[2], op_a[1], op_a[0]};
        bus.req_b_i = {op_b[3], op_b[2], op_b[1], op_b[0]};
        bus.req_valid_i = '0;

        // valid, ready, rsp, idle per cycle from reset with all requesters hammering
        tbl[0]  = '{4'b1111, 4'b0001, 4'b0000, 1'b1};
        tbl[1]  = '{4'b1111, 4'b0010, 4'b0000, 1'b0};
        tbl[2]  = '{4'b1111, 4'b0100, 4'b0000, 1'b0};
        tbl[3]  = '{4'b1111, 4'b1000, 4'b0000, 1'b0};
        tbl[4]  = '{4'b1111, 4'b0001, 4'b0001, 1'b0};
        tbl[5]  = '{4'b1111, 4'b0010, 4'b0010, 1'b0};
        tbl[6]  = '{4'b1111, 4'b0100, 4'b0100, 1'b0};
        tbl[7]  = '{4'b1111, 4'b1000, 4'b1000, 1'b0};
        tbl[8]  = '{4'b0000, 4'b0000, 4'b0001, 1'b0};
        tbl[9]  = '{4'b0000, 4'b0000, 4'b0010, 1'b0};
        tbl[10] = '{4'b0000, 4'b0000, 4'b0100, 1'b0};
        tbl[11] = '{4'b0000, 4'b0000, 4'b1000, 1'b1};

        next_cycle();
        do_reset();
        reset_checks("reset");

        // Single op on requester 1
        drive_chk("single_ready", 4'b0010, 4'b0010);
        bus.req_valid_i = '0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 3) begin
                check("single_rsp_early", bus.rsp_valid_o, 0);
                check("single_busy", bus.idle_o, 0);
            end
            next_cycle();
        end
        @(negedge clk);
        check("single_rsp", bus.rsp_valid_o, 4'b0010);
        check("single_data", bus.rsp_data_o, 32'h4040_0000);
        check("single_idle", bus.idle_o, 1);
        next_cycle();
        drain("single");

        // Round-robin table from a fresh reset
        do_reset();
        for (int i = 0; i < 12; i++) begin
            bus.req_valid_i = tbl[i].valid;
            @(negedge clk);
            check($sformatf("rr_ready_%0d", i), bus.req_ready_o, tbl[i].ready);
            check($sformatf("rr_rsp_%0d", i), bus.rsp_valid_o, tbl[i].rsp);
            check($sformatf("rr_idle_%0d", i), bus.idle_o, tbl[i].idle);
            next_cycle();
        end
        drain("rr");

        // Busy blocking: requester 2 held valid
        for (int k = 0; k <= 12; k++) begin
            bus.req_valid_i = (k < 10) ? 4'b0100 : 4'b0000;
            @(negedge clk);
            check($sformatf("busy_ready_%0d", k), bus.req_ready_o,
                  (k < 10 && k % 4 == 0) ? 4'b0100 : 4'b0000);
            check($sformatf("busy_mulv_%0d", k), bus.mul_valid_o, (k % 4 == 1) ? 1 : 0);
            check($sformatf("busy_rsp_%0d", k), bus.rsp_valid_o,
                  (k > 0 && k % 4 == 0) ? 4'b0100 : 4'b0000);
            next_cycle();
        end
        drain("busy");

`ifndef FPU_MUL_ARB_PRIO_EN
        // Wrap-around: ptr is 3 after the requester 2 grant
        drive_chk("wrap_g3", 4'b1001, 4'b1000);
        drive_chk("wrap_g0", 4'b1001, 4'b0001);
        drain("wrap");
        drive_chk("wrap_ptr1", 4'b0101, 4'b0100);
        drain("wrap_ptr");
`endif

        // Reset mid-flight after two acceptances
        drive_chk("mid_g0", 4'b0011, 4'b0001);
        drive_chk("mid_g1", 4'b0011, 4'b0010);
        bus.req_valid_i = '0;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        reset_checks("mid_reset");
        rc0 = rsp_cnt;
        repeat (8) next_cycle();
        check("mid_no_rsp", rsp_cnt, rc0);
        check("mid_idle", bus.idle_o, 1);
        drive_chk("mid_regrant", 4'b1111, 4'b0001);
        drain("mid");

`ifdef FPU_MUL_ARB_PRIO_EN
        // Priority: move ptr to 2, then requester 0 preempts without moving ptr
        drive_chk("prio_setup", 4'b0010, 4'b0010);
        drain("prio_setup");
        drive_chk("prio_g0", 4'b0111, 4'b0001);
        drive_chk("prio_g2", 4'b0110, 4'b0100);
        drain("prio");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
